pong_score_keeper: RTL

//  Downstream of the ball-position controller. Consumes its per-side miss pulses (count1 = ball hit left edge,

---
 rtl/pong_pkg.sv | 22 ++
 rtl/bcd_counter2.sv | 34 +++
 rtl/pong_score_keeper.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared encodings for the pong score keeper: FSM states, winner codes, BCD width.
// Optional build macro SCORE_DEUCE_EN is consumed by pong_score_keeper.
package pong_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    POINT_HOLD = 2'd1,
    GAME_OVER  = 2'd2
  } state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  localparam int BCD_W = 8;

  // Binary score increment that sticks at 99 so it tracks the BCD counter.
  function automatic logic [6:0] sat_inc(input logic [6:0] s);
    return (s >= 7'd99) ? s : s + 7'd1;
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter with synchronous clear and increment enable, saturating at 99.
module bcd_counter2
  import pong_pkg::*;
(
  input  logic             clk2,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] bcd
);

  logic [3:0] tens;
  logic [3:0] units;

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (clr) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (inc && !(tens == 4'd9 && units == 4'd9)) begin
      if (units == 4'd9) begin
        units <= 4'd0;
        tens  <= tens + 4'd1;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

  assign bcd = {tens, units};

endmodule

// File: rtl/pong_score_keeper.sv
// Pong score keeper: edge-detects miss pulses, keeps binary/BCD scores, serve pause and match end.
// Define SCORE_DEUCE_EN to require a two-point lead to win (99 always wins).
module pong_score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 11,
  parameter int HOLD_CYCLES = 50000000,
  parameter int HOLD_W      = 26
) (
  input  logic             clk2,
  input  logic             rst_n,
  input  logic             count1,
  input  logic             count2,
  input  logic             restart,
  output logic [BCD_W-1:0] score1_bcd,
  output logic [BCD_W-1:0] score2_bcd,
  output logic             serve_hold,
  output logic             point_p1,
  output logic             point_p2,
  output logic [1:0]       winner
);

  localparam logic [6:0]        WIN7      = 7'(WIN_SCORE);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  state_t            state, state_nx;
  logic [6:0]        score1, score2, score1_nx, score2_nx;
  logic [HOLD_W-1:0] timer, timer_nx;
  logic [1:0]        winner_nx;
  logic              point_p1_nx, point_p2_nx;
  logic              inc1, inc2, clr;
  logic              c1_d, c2_d;
  logic              ev1, ev2;

  assign ev1 = count1 & ~c1_d;
  assign ev2 = count2 & ~c2_d;

  // Win test on post-increment scores; 'a' is the player who just scored.
  function automatic logic win_check(input logic [6:0] a, input logic [6:0] b);
`ifdef SCORE_DEUCE_EN
    return ((a >= WIN7) && (a >= b + 7'd2)) || (a == 7'd99);
`else
    return (b == b) && (a >= WIN7);
`endif
  endfunction

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PLAY;
      score1   <= 7'd0;
      score2   <= 7'd0;
      timer    <= '0;
      winner   <= WINNER_NONE;
      point_p1 <= 1'b0;
      point_p2 <= 1'b0;
      c1_d     <= 1'b0;
      c2_d     <= 1'b0;
    end else begin
      state    <= state_nx;
      score1   <= score1_nx;
      score2   <= score2_nx;
      timer    <= timer_nx;
      winner   <= winner_nx;
      point_p1 <= point_p1_nx;
      point_p2 <= point_p2_nx;
      c1_d     <= count1;
      c2_d     <= count2;
    end
  end

  always_comb begin
    state_nx    = state;
    score1_nx   = score1;
    score2_nx   = score2;
    timer_nx    = timer;
    winner_nx   = winner;
    point_p1_nx = 1'b0;
    point_p2_nx = 1'b0;
    inc1        = 1'b0;
    inc2        = 1'b0;
    clr         = 1'b0;
    case (state)
      PLAY: begin
        // Simultaneous misses on both sides cancel out.
        if (ev2 && !ev1) begin
          score1_nx   = sat_inc(score1);
          inc1        = 1'b1;
          point_p1_nx = 1'b1;
          if (win_check(score1_nx, score2)) begin
            state_nx  = GAME_OVER;
            winner_nx = WINNER_P1;
          end else begin
            state_nx = POINT_HOLD;
            timer_nx = '0;
          end
        end else if (ev1 && !ev2) begin
          score2_nx   = sat_inc(score2);
          inc2        = 1'b1;
          point_p2_nx = 1'b1;
          if (win_check(score2_nx, score1)) begin
            state_nx  = GAME_OVER;
            winner_nx = WINNER_P2;
          end else begin
            state_nx = POINT_HOLD;
            timer_nx = '0;
          end
        end
      end
      POINT_HOLD: begin
        if (timer == HOLD_LAST) state_nx = PLAY;
        else                    timer_nx = timer + HOLD_ONE;
      end
      GAME_OVER: begin
        if (restart) begin
          clr       = 1'b1;
          score1_nx = 7'd0;
          score2_nx = 7'd0;
          winner_nx = WINNER_NONE;
          state_nx  = PLAY;
        end
      end
      default: state_nx = PLAY;
    endcase
  end

  assign serve_hold = (state != PLAY);

  bcd_counter2 u_bcd1 (
    .clk2  (clk2),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc1),
    .bcd   (score1_bcd)
  );

  bcd_counter2 u_bcd2 (
    .clk2  (clk2),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc2),
    .bcd   (score2_bcd)
  );

endmodule
